// File: rtl/acc_feeder_pkg.sv
// Shared definitions for the accelerator feeder: CPU register offsets,
// accelerator command offsets, CTRL/STATUS bit positions and the FSM states.
package acc_feeder_pkg;

  // CPU register offsets
  localparam logic [3:0] REG_SRC    = 4'd0;
  localparam logic [3:0] REG_LEN    = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;
  localparam logic [3:0] REG_RESULT = 4'd4;

  // Accelerator command offsets
  localparam logic [3:0] ACC_DATA  = 4'd0;
  localparam logic [3:0] ACC_READ  = 4'd1;
  localparam logic [3:0] ACC_CLEAR = 4'd2;

  // CTRL / STATUS bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQCLR_BIT = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_STREAM = 3'd2,
    ST_RDREQ  = 3'd3,
    ST_RDCAP  = 3'd4
  } state_e;

endpackage

// File: rtl/acc_feeder_regs.sv
// CPU register file and read-back mux for the accelerator feeder.
// Optional feature macro: ACC_FEEDER_IRQ_EN (irq flag set on completion,
// cleared by CTRL bit1). Without it irq is tied low and CTRL bit1 is ignored.
//
// CPU port handshake: cpu_en is a single-cycle request strobe with no
// backpressure; cpu_we selects write. A read request in cycle N returns its
// data on cpu_dout in cycle N+1; cpu_dout is 0 in every other cycle.
module acc_feeder_regs
  import acc_feeder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cpu_addr_i,
  input  logic              cpu_en_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_din_i,
  output logic [31:0]       cpu_dout_o,
  input  logic              busy_i,
  input  logic              cap_i,
  input  logic [31:0]       cap_data_i,
  output logic              start_o,
  output logic [ADDR_W-1:0] src_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              irq_o
);

  logic              wr_en;
  logic              rd_en;
  logic              ctrl_wr;
  logic [ADDR_W-1:0] src_q;
  logic [LEN_W-1:0]  len_q;
  logic [31:0]       result_q;
  logic              done_q;
  logic [31:0]       rdata_d;
  logic [31:0]       cpu_dout_q;
  logic              unused_din;

  assign wr_en   = cpu_en_i & cpu_we_i;
  assign rd_en   = cpu_en_i & ~cpu_we_i;
  assign ctrl_wr = wr_en && (cpu_addr_i == REG_CTRL);
  // Start only counts when the sequencer is idle; while busy it is dropped.
  assign start_o = ctrl_wr && cpu_din_i[CTRL_START_BIT] && !busy_i;
  assign src_o   = src_q;
  assign len_o   = len_q;
  // Upper data bits beyond the register widths are intentionally dropped.
  assign unused_din = ^cpu_din_i;

  // SRC/LEN are frozen while a transfer is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      len_q <= '0;
    end else if (wr_en && !busy_i) begin
      if (cpu_addr_i == REG_SRC) src_q <= cpu_din_i[ADDR_W-1:0];
      if (cpu_addr_i == REG_LEN) len_q <= cpu_din_i[LEN_W-1:0];
    end
  end

  // RESULT and done: captured at completion, done cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (cap_i) begin
      result_q <= cap_data_i;
      done_q   <= 1'b1;
    end else if (start_o) begin
      done_q   <= 1'b0;
    end
  end

`ifdef ACC_FEEDER_IRQ_EN
  logic irq_q;

  // Interrupt flag: completion sets it and wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (cap_i) begin
      irq_q <= 1'b1;
    end else if (ctrl_wr && cpu_din_i[CTRL_IRQCLR_BIT]) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux: unmapped offsets and non-read cycles return 0
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (cpu_addr_i)
        REG_SRC:    rdata_d = 32'(src_q);
        REG_LEN:    rdata_d = 32'(len_q);
        REG_STATUS: begin
          rdata_d[STAT_BUSY_BIT] = busy_i;
          rdata_d[STAT_DONE_BIT] = done_q;
        end
        REG_RESULT: rdata_d = result_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Registered read data, one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_dout_q <= '0;
    else        cpu_dout_q <= rdata_d;
  end

  assign cpu_dout_o = cpu_dout_q;

endmodule

// File: rtl/acc_feeder.sv
// Accelerator feeder: streams LEN words from data memory starting at SRC into
// the min-accelerator, then reads back and latches the minimum into RESULT.
// Optional feature macro: ACC_FEEDER_IRQ_EN enables the completion interrupt.
module acc_feeder
  import acc_feeder_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cpu_addr,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              acc_en,
  output logic              acc_we,
  output logic [3:0]        acc_addr,
  output logic [31:0]       acc_din,
  input  logic [31:0]       acc_dout,
  output logic              irq
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W:0]    cnt_nxt;
  logic              busy;
  logic              start;
  logic              cap;
  logic              last_push;
  logic              more_reads;
  logic              len_zero;
  logic [ADDR_W-1:0] src;
  logic [LEN_W-1:0]  len;

  acc_feeder_regs #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr_i (cpu_addr),
    .cpu_en_i   (cpu_en),
    .cpu_we_i   (cpu_we),
    .cpu_din_i  (cpu_din),
    .cpu_dout_o (cpu_dout),
    .busy_i     (busy),
    .cap_i      (cap),
    .cap_data_i (acc_dout),
    .start_o    (start),
    .src_o      (src),
    .len_o      (len),
    .irq_o      (irq)
  );

  // cnt_q counts words already pushed; word cnt_q+1 is the next one to read.
  assign busy       = (state_q != ST_IDLE);
  assign len_zero   = (len == '0);
  assign cnt_nxt    = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign last_push  = (cnt_nxt == {1'b0, len});
  assign more_reads = (cnt_nxt < {1'b0, len});

  // State and word-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLR;
      end
      ST_CLR: begin
        cnt_d   = '0;
        state_d = len_zero ? ST_RDREQ : ST_STREAM;
      end
      ST_STREAM: begin
        cnt_d = cnt_nxt[LEN_W-1:0];
        if (last_push) state_d = ST_RDREQ;
      end
      ST_RDREQ: state_d = ST_RDCAP;
      ST_RDCAP: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory and accelerator command outputs, decoded from the current state
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    acc_en   = 1'b0;
    acc_we   = 1'b0;
    acc_addr = '0;
    acc_din  = '0;
    cap      = 1'b0;
    case (state_q)
      ST_CLR: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = ACC_CLEAR;
        if (!len_zero) begin
          mem_en   = 1'b1;
          mem_addr = src;
        end
      end
      ST_STREAM: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = ACC_DATA;
        acc_din  = mem_rdata;
        if (more_reads) begin
          mem_en   = 1'b1;
          mem_addr = src + ADDR_W'(cnt_nxt);
        end
      end
      ST_RDREQ: begin
        acc_en   = 1'b1;
        acc_addr = ACC_READ;
      end
      ST_RDCAP: cap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/acc_feeder.md
ACC_FEEDER -- requirements
Module: acc_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: word-address width of the source data-memory port.
REQ-002 SHALL have parameter LEN_W, default 16: width of the transfer-length register.
REQ-003 SHALL have port clk, input, 1: single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have CPU-side ports cpu_addr in 4, cpu_en in 1, cpu_we in 1, cpu_din in 32 and cpu_dout out 32: register access.
REQ-006 SHALL have memory ports mem_en out 1, mem_addr out ADDR_W and mem_rdata in 32: synchronous read, data valid one cycle after mem_en.
REQ-007 SHALL have accelerator ports acc_en out 1, acc_we out 1, acc_addr out 4, acc_din out 32 and acc_dout in 32: drives the min-accelerator command port.
REQ-008 SHALL have port irq, output, 1: completion interrupt.

Function
REQ-009 Register map SHALL be:
- 0 SRC: RW base word address.
- 1 LEN: RW word count.
- 2 CTRL: W only; bit0 start, bit1 irq clear.
- 3 STATUS: R; bit0 busy, bit1 done.
- 4 RESULT: R; last captured minimum.
REQ-010 CPU reads SHALL return data on cpu_dout one cycle after cpu_en&!cpu_we; unmapped addresses and cycles with no read SHALL return 0.
REQ-011 FSM states SHALL be IDLE, CLR, STREAM, RDREQ and RDCAP.
REQ-012 Start SHALL be accepted only in IDLE; in IDLE it clears done and moves the FSM to CLR; while busy it is ignored.
REQ-013 Writes to SRC and LEN while busy SHALL be ignored.
REQ-014 CLR SHALL last one cycle:
- acc_en=1, acc_we=1, acc_addr=2.
- If LEN!=0, also issue the mem read of word 0 and go to STREAM; otherwise go to RDREQ.
REQ-015 STREAM SHALL push one word per cycle:
- acc_en=1, acc_we=1, acc_addr=0, acc_din=mem_rdata.
- Issue the next mem read while words remain.
- After the LEN-th push, go to RDREQ.
REQ-016 mem_addr SHALL equal SRC+i modulo 2^ADDR_W, so the address wraps silently.
REQ-017 RDREQ SHALL drive acc_en=1, acc_we=0, acc_addr=1 for one cycle.
REQ-018 RDCAP SHALL latch acc_dout into RESULT, set done, set the irq flag and return to IDLE.
REQ-019 For a start accepted at edge T with LEN=N>0, pushes SHALL occur in cycles T+2..T+N+1 and done SHALL read 1 from cycle T+N+4.
REQ-020 For LEN=0, done SHALL read 1 from cycle T+4 and RESULT SHALL be FFFF_FFFF.
REQ-021 When irq clear and the done event occur in the same cycle, set SHALL win.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 acc_en, acc_we and mem_en SHALL be 0 in IDLE, and acc_addr/acc_din SHALL be 0 whenever acc_en=0.

Reset
REQ-024 rst_n low SHALL immediately force:
- FSM to IDLE.
- SRC, LEN, RESULT and cpu_dout to 0.
- done, irq, acc_en, acc_we and mem_en to 0.
REQ-025 Reset mid-transfer SHALL abort with no further accelerator or memory accesses.

Configuration
REQ-026 With ACC_FEEDER_IRQ_EN defined, irq SHALL follow the irq flag: set at RDCAP, cleared by CTRL bit1.
REQ-027 Without ACC_FEEDER_IRQ_EN, irq SHALL be tied 0, CTRL bit1 SHALL be ignored, and the port list SHALL be unchanged.

Structure
REQ-028 Shared package acc_feeder_pkg SHALL hold:
- CPU register offsets 0..4.
- Accelerator command offsets (DATA=0, READ=1, CLEAR=2).
- CTRL/STATUS bit positions.
- FSM state enum.
REQ-029 The CPU register file and read-mux SHALL be the single sub-module acc_feeder_regs; sequencing SHALL stay in acc_feeder.

Verification
REQ-030 Memory [7,3,9,5] at SRC=0x10, LEN=4, start -> four pushes in consecutive cycles, RESULT=3, done=1 at T+8, irq=1.
REQ-031 LEN=0, start -> no mem_en, exactly one clear and one read command, RESULT=FFFF_FFFF, done at T+4.
REQ-032 SRC=0xFFE, LEN=4 -> mem_addr sequence FFE, FFF, 000, 001.
REQ-033 Start and SRC write issued mid-transfer -> ignored; the original transfer completes with unchanged addresses.
REQ-034 rst_n pulsed low during STREAM -> outputs 0 at once, FSM in IDLE, a fresh start runs normally.
REQ-035 irq clear written in the RDCAP cycle -> irq stays 1; a later clear -> irq 0, and irq is constant 0 with ACC_FEEDER_IRQ_EN undefined.
